// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner. It drives one column at a time and debounces the
// press and the release of a single key, then encodes that key into strobes and levels for gencon.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_input
);
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    row_meta_reg, row_s_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    col_reg, col_next;
    logic [3:0]    row_lat_reg, row_lat_next;
    logic [3:0]    key_reg, key_next;
    logic [2:0]    op_reg, op_next;
    logic          read_reg, read_next;
    logic          equal_reg, equal_next;
    logic          clear_reg, clear_next;

    logic [3:0]    low_bits;
    logic          single_low;
    logic [1:0]    row_idx;
    logic [3:0]    key_code;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_n[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign keypad_input   = key_reg;
    assign read_input     = read_reg;
    assign operator_input = op_reg;
    assign equal_input    = equal_reg;
    assign clear_input    = clear_reg;

    // Ghosting and multi-key patterns show up as more than one low row; only a lone low row is a press.
    assign low_bits   = ~row_s_reg;
    assign single_low = (low_bits != 4'd0) && ((low_bits & (low_bits - 4'd1)) == 4'd0);

    always_comb begin
        case (row_lat_reg)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    assign key_code = {row_idx, col_reg};

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        col_next     = col_reg;
        row_lat_next = row_lat_reg;
        key_next     = key_reg;
        op_next      = op_reg;
        read_next    = 1'b0;
        equal_next   = 1'b0;
        clear_next   = 1'b0;

        case (state_reg)
            SCAN: begin
                if (cnt_reg == SCAN_LAST) begin
                    cnt_next = '0;
                    if (single_low) begin
                        row_lat_next = row_s_reg;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s_reg != row_lat_reg) begin
                    state_next = SCAN;
                    cnt_next   = '0;
                    col_next   = col_reg + 2'd1;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = EMIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            EMIT: begin
                state_next = WAIT_RELEASE;
                cnt_next   = '0;
                // Index is {row, column}: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
                case (key_code)
                    4'd0:  begin key_next = 4'd1; read_next = 1'b1; end
                    4'd1:  begin key_next = 4'd2; read_next = 1'b1; end
                    4'd2:  begin key_next = 4'd3; read_next = 1'b1; end
                    4'd3:  op_next = 3'b001;
                    4'd4:  begin key_next = 4'd4; read_next = 1'b1; end
                    4'd5:  begin key_next = 4'd5; read_next = 1'b1; end
                    4'd6:  begin key_next = 4'd6; read_next = 1'b1; end
                    4'd7:  op_next = 3'b010;
                    4'd8:  begin key_next = 4'd7; read_next = 1'b1; end
                    4'd9:  begin key_next = 4'd8; read_next = 1'b1; end
                    4'd10: begin key_next = 4'd9; read_next = 1'b1; end
                    4'd11: op_next = 3'b100;
                    4'd12: begin clear_next = 1'b1; op_next = 3'b000; end
                    4'd13: begin key_next = 4'd0; read_next = 1'b1; end
                    4'd14: equal_next = 1'b1;
                    default: ;
                endcase
            end
            WAIT_RELEASE: begin
                if (row_s_reg != 4'b1111) begin
                    cnt_next = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = SCAN;
                    cnt_next   = '0;
                    col_next   = col_reg + 2'd1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = SCAN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg    <= SCAN;
            row_meta_reg <= 4'b1111;
            row_s_reg    <= 4'b1111;
            cnt_reg      <= '0;
            col_reg      <= 2'd0;
            row_lat_reg  <= 4'b1111;
            key_reg      <= 4'd0;
            op_reg       <= 3'b000;
            read_reg     <= 1'b0;
            equal_reg    <= 1'b0;
            clear_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_meta_reg <= row_n;
            row_s_reg    <= row_meta_reg;
            cnt_reg      <= cnt_next;
            col_reg      <= col_next;
            row_lat_reg  <= row_lat_next;
            key_reg      <= key_next;
            op_reg       <= op_next;
            read_reg     <= read_next;
            equal_reg    <= equal_next;
            clear_reg    <= clear_next;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner. A key-matrix model drives the rows, and a
// keymap-level reference model queues the expected events that a separate monitor pops and compares.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    localparam logic [1:0] K_DIGIT = 2'd0;
    localparam logic [1:0] K_OP    = 2'd1;
    localparam logic [1:0] K_EQUAL = 2'd2;
    localparam logic [1:0] K_CLEAR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] value;
    } ev_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;
    logic       clear_input;

    logic       pressed [0:3][0:3];
    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] model_op = 3'b000;
    string      keymap = "123A456B789C*0#D";
    string      kind_name [0:3] = '{"digit", "operator", "equal", "clear"};

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .RST(RST), .row_n(row_n), .col_n(col_n),
        .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input),
        .clear_input(clear_input)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column, so a row reads low only while that column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end else begin
            $display("check %s: %0d ok", name, got);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        pressed[k / 4][k % 4] = v;
    endtask

    // Reference model: what the keypad legend says a single accepted key press must produce.
    task automatic model_key(input int k);
        byte        ch;
        ev_t        e;
        logic [2:0] new_op;
        ch = keymap.getc(k);
        if (ch >= "0" && ch <= "9") begin
            e.kind = K_DIGIT; e.value = 4'(ch - "0"); exp_q.push_back(e);
        end else if (ch == "A" || ch == "B" || ch == "C") begin
            new_op = (ch == "A") ? 3'b001 : (ch == "B") ? 3'b010 : 3'b100;
            if (new_op != model_op) begin
                e.kind = K_OP; e.value = {1'b0, new_op}; exp_q.push_back(e);
            end
            model_op = new_op;
        end else if (ch == "#") begin
            e.kind = K_EQUAL; e.value = 4'd0; exp_q.push_back(e);
        end else if (ch == "*") begin
            e.kind = K_CLEAR; e.value = 4'd0; exp_q.push_back(e);
            model_op = 3'b000;
        end
    endtask

    task automatic press(input int k, input int hold, input int gap, input bit expect_it);
        if (expect_it) model_key(k);
        set_key(k, 1'b1);
        repeat (hold) @(posedge clk);
        set_key(k, 1'b0);
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_col_entry(input logic [3:0] target);
        logic [3:0] prev;
        bit         found;
        prev  = col_n;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (col_n == target && prev != target) found = 1'b1;
            prev = col_n;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL col_wait: column %b never became driven within 64 cycles", target);
        end
    endtask

    task automatic got_event(input logic [1:0] kind, input logic [3:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s value %0d, required no event", kind_name[kind], val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.value !== val) begin
                errors++;
                $display("FAIL event: got %s value %0d, required %s value %0d",
                         kind_name[kind], val, kind_name[e.kind], e.value);
            end else begin
                $display("event %s value %0d ok", kind_name[kind], val);
            end
        end
    endtask

    // Monitor: every strobe or operator-level change is an event to match against the queue.
    initial begin
        logic [2:0] prev_op;
        int         n;
        prev_op = 3'b000;
        forever begin
            @(negedge clk);
            if (RST) begin
                prev_op = operator_input;
            end else begin
                n = 0;
                if (read_input)  n++;
                if (equal_input) n++;
                if (clear_input) n++;
                if (n > 1) begin
                    checks++; errors++;
                    $display("FAIL strobe_overlap: got %0d strobes high, required at most 1", n);
                end
                if (read_input)       got_event(K_DIGIT, keypad_input);
                else if (equal_input) got_event(K_EQUAL, 4'd0);
                else if (clear_input) got_event(K_CLEAR, {1'b0, operator_input});
                else if (operator_input != prev_op) got_event(K_OP, {1'b0, operator_input});
                prev_op = operator_input;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1000000, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_cols [0:3];
        logic [3:0] prev;
        int         idx, run;
        bit         first;
        int         k;
        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;

        // Reset state, then free-running column rotation.
        RST = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_col_n", int'(col_n), 4'b1110);
        check("reset_read", int'(read_input), 0);
        check("reset_equal", int'(equal_input), 0);
        check("reset_clear", int'(clear_input), 0);
        check("reset_operator", int'(operator_input), 0);
        check("reset_keypad", int'(keypad_input), 0);
        RST = 1'b0;
        check("rotate_start", int'(col_n), 4'b1110);
        prev = col_n; idx = 0; run = 1; first = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (col_n != prev) begin
                idx = (idx + 1) % 4;
                check("col_rotate", int'(col_n), int'(exp_cols[idx]));
                if (!first) check("col_period", run, SCAN_DIV);
                first = 1'b0; run = 1; prev = col_n;
            end else begin
                run++;
            end
        end

        // Long hold of '5': a single event, no auto-repeat.
        press(5, 200, 20, 1'b1);

        // 1 2 A 3 4 #
        press(0, 50, 20, 1'b1);
        press(1, 50, 20, 1'b1);
        press(3, 50, 20, 1'b1);
        press(2, 50, 20, 1'b1);
        press(4, 50, 20, 1'b1);
        press(14, 50, 20, 1'b1);

        // Bouncing '7' never settles long enough, then a clean press.
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[2][0] = !pressed[2][0];
            @(posedge clk);
        end
        set_key(8, 1'b0);
        repeat (20) @(posedge clk);
        press(8, 50, 20, 1'b1);

        // '1' and '4' together share column 0: two low rows, never a press.
        set_key(0, 1'b1); set_key(4, 1'b1);
        repeat (60) @(posedge clk);
        set_key(0, 1'b0); set_key(4, 1'b0);
        repeat (20) @(posedge clk);

        // '2' held, then '3' added: only '2' counts.
        model_key(1);
        set_key(1, 1'b1);
        repeat (40) @(posedge clk);
        set_key(2, 1'b1);
        repeat (40) @(posedge clk);
        set_key(1, 1'b0); set_key(2, 1'b0);
        repeat (20) @(posedge clk);

        // B then *: operator set, then cleared with the clear strobe.
        press(7, 50, 20, 1'b1);
        press(12, 50, 20, 1'b1);

        // Reset mid-debounce of '9' while an operator is active.
        press(11, 50, 20, 1'b1);
        wait_col_entry(4'b1101);
        set_key(10, 1'b1);
        wait_col_entry(4'b1011);
        repeat (9) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        model_op = 3'b000;
        repeat (3) @(negedge clk);
        check("midreset_col_n", int'(col_n), 4'b1110);
        check("midreset_operator", int'(operator_input), 0);
        check("midreset_read", int'(read_input), 0);
        check("midreset_keypad", int'(keypad_input), 0);
        check("midreset_pending", exp_q.size(), 0);
        RST = 1'b0;
        model_key(10);
        repeat (60) @(posedge clk);
        set_key(10, 1'b0);
        repeat (20) @(posedge clk);

        // Random single-key presses, including the ignored 'D'.
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(15, 0);
            press(k, $urandom_range(80, 40), $urandom_range(30, 20), 1'b1);
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_operator", int'(operator_input), int'(model_op));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
